// File: rtl/lam_pkg.sv
// Shared definitions for the load/store sequencer: funct3 encodings, command
// field layout, FSM states, error codes and the legality helpers.
package lam_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam int unsigned CTL_STORE_BIT = 8;
    localparam int unsigned CTL_F3_LSB    = 5;
    localparam int unsigned CTL_REG_LSB   = 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WB,
        S_ERR
    } lam_state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_FUNCT3   = 2'b10,
        ERR_TIMEOUT  = 2'b11
    } lam_err_e;

    function automatic logic lam_f3_illegal(input logic is_store, input logic [2:0] f3);
        if (is_store) begin
            return (f3 > F3_SW);
        end
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    // funct3[1:0] encodes access size for both loads and stores.
    function automatic logic lam_misaligned(input logic [2:0] f3, input logic [1:0] off);
        return ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/lam_ctrl_if.sv
// Request/ack data-memory port between the sequencer (master) and memory (slave).
interface lam_ctrl_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_be,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_be,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );

endinterface

// File: rtl/lam_align.sv
// Combinational byte-lane steering: store enables/data replication and
// load lane selection with sign or zero extension.
module lam_align
    import lam_pkg::*;
(
    input  logic [2:0]  st_funct3_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_wdata_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    logic [31:0] lane;

    always_comb begin
        st_be_o    = '0;
        st_wdata_o = '0;
        case (st_funct3_i)
            F3_SB: begin
                st_be_o    = 4'b0001 << st_off_i;
                st_wdata_o = {4{st_data_i[7:0]}};
            end
            F3_SH: begin
                st_be_o    = 4'b0011 << st_off_i;
                st_wdata_o = {2{st_data_i[15:0]}};
            end
            default: begin
                st_be_o    = '1;
                st_wdata_o = st_data_i;
            end
        endcase
    end

    assign lane = ld_rdata_i >> {ld_off_i, 3'b000};

    always_comb begin
        ld_data_o = ld_rdata_i;
        case (ld_funct3_i)
            F3_LB:   ld_data_o = {{24{lane[7]}}, lane[7:0]};
            F3_LH:   ld_data_o = {{16{lane[15]}}, lane[15:0]};
            F3_LBU:  ld_data_o = {24'h0, lane[7:0]};
            F3_LHU:  ld_data_o = {16'h0, lane[15:0]};
            default: ld_data_o = ld_rdata_i;
        endcase
    end

endmodule

// File: rtl/lam_ctrl.sv
// Load/store sequencer: legality check, request/ack memory access, writeback.
// Optional LAM_TIMEOUT_EN aborts a request that sees no ack for TIMEOUT_CYCLES.
module lam_ctrl
    import lam_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lam_new,
    input  logic [8:0]        lam_control,
    input  logic [31:0]       eff_addr,
    input  logic [31:0]       store_data,
    lam_ctrl_if.master        mem,
    output logic              stall,
    output logic              wb_en,
    output logic [4:0]        wb_sel,
    output logic [31:0]       wb_data,
    output logic              lam_err,
    output logic [1:0]        lam_err_code
);

    lam_state_e  state_q, state_d;

    logic        cmd_store_q, cmd_store_d;
    logic [2:0]  cmd_f3_q, cmd_f3_d;
    logic [4:0]  cmd_reg_q, cmd_reg_d;
    logic [1:0]  cmd_off_q, cmd_off_d;

    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;

    logic        wb_en_q, wb_en_d;
    logic [4:0]  wb_sel_q, wb_sel_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        err_q, err_d;
    lam_err_e    err_code_q, err_code_d;

    logic        in_store;
    logic [2:0]  in_f3;
    logic [4:0]  in_reg;
    logic        start;
    logic        tmo_hit;

    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_ld_data;

    assign in_store = lam_control[CTL_STORE_BIT];
    assign in_f3    = lam_control[CTL_F3_LSB +: 3];
    assign in_reg   = lam_control[CTL_REG_LSB +: 5];
    assign start    = (state_q == S_IDLE) && (lam_new || in_store);

    lam_align u_align (
        .st_funct3_i (in_f3),
        .st_off_i    (eff_addr[1:0]),
        .st_data_i   (store_data),
        .st_be_o     (al_be),
        .st_wdata_o  (al_wdata),
        .ld_funct3_i (cmd_f3_q),
        .ld_off_i    (cmd_off_q),
        .ld_rdata_i  (mem.mem_rdata),
        .ld_data_o   (al_ld_data)
    );

`ifdef LAM_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt_q counts completed ack-less REQ cycles, so the abort fires in the
    // TIMEOUT_CYCLES-th one unless that same cycle carries the ack.
    assign tmo_hit = (state_q == S_REQ) && !mem.mem_ack &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if ((state_q == S_REQ) && !mem.mem_ack) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = ^{TIMEOUT_CYCLES, CNT_W};
    assign tmo_hit        = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cmd_store_d = cmd_store_q;
        cmd_f3_d    = cmd_f3_q;
        cmd_reg_d   = cmd_reg_q;
        cmd_off_d   = cmd_off_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        wb_en_d     = 1'b0;
        wb_sel_d    = wb_sel_q;
        wb_data_d   = wb_data_q;
        err_d       = 1'b0;
        err_code_d  = ERR_NONE;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cmd_store_d = in_store;
                    cmd_f3_d    = in_f3;
                    cmd_reg_d   = in_reg;
                    cmd_off_d   = eff_addr[1:0];
                    if (lam_f3_illegal(in_store, in_f3)) begin
                        state_d    = S_ERR;
                        err_d      = 1'b1;
                        err_code_d = ERR_FUNCT3;
                    end else if (lam_misaligned(in_f3, eff_addr[1:0])) begin
                        state_d    = S_ERR;
                        err_d      = 1'b1;
                        err_code_d = ERR_MISALIGN;
                    end else begin
                        state_d = S_REQ;
                        req_d   = 1'b1;
                        we_d    = in_store;
                        addr_d  = {eff_addr[31:2], 2'b00};
                        be_d    = in_store ? al_be : 4'b1111;
                        wdata_d = al_wdata;
                    end
                end
            end
            S_REQ: begin
                if (mem.mem_ack) begin
                    req_d = 1'b0;
                    if (cmd_store_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_WB;
                        wb_en_d   = (cmd_reg_q != 5'd0);
                        wb_sel_d  = cmd_reg_q;
                        wb_data_d = al_ld_data;
                    end
                end else if (tmo_hit) begin
                    req_d      = 1'b0;
                    state_d    = S_ERR;
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end
            end
            S_WB:    state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cmd_store_q <= 1'b0;
            cmd_f3_q    <= '0;
            cmd_reg_q   <= '0;
            cmd_off_q   <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            wb_en_q     <= 1'b0;
            wb_sel_q    <= '0;
            wb_data_q   <= '0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            cmd_store_q <= cmd_store_d;
            cmd_f3_q    <= cmd_f3_d;
            cmd_reg_q   <= cmd_reg_d;
            cmd_off_q   <= cmd_off_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            wb_en_q     <= wb_en_d;
            wb_sel_q    <= wb_sel_d;
            wb_data_q   <= wb_data_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    // A store releases upstream in its ack cycle; a load holds until WB.
    assign stall = start || ((state_q == S_REQ) && !(mem.mem_ack && cmd_store_q));

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_wdata = wdata_q;

    assign wb_en        = wb_en_q;
    assign wb_sel       = wb_sel_q;
    assign wb_data      = wb_data_q;
    assign lam_err      = err_q;
    assign lam_err_code = err_code_q;

endmodule
